display_writer: RTL and testbench
=================================

# display_writer

Character-stream front end for `display_ram`. Accepts ASCII bytes over a valid/ready handshake and converts them to the 6-bit display code. Maintains a text cursor and writes characters into the RAM through its write port. Uses the RAM read port only for hardware scroll, and blanks the screen on reset and on form-feed.

## Interface

Parameters:
- `COLS`, default 40: characters per row.
- `ROWS`, default 25: rows per screen. `COLS*ROWS` must be ≤ 2048.
- `BLANK`, default 6'h20: display code written when clearing.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `char_valid`  in  1: `char_data` is valid.
- `char_data`  in  8: ASCII byte.
- `char_ready`  out  1: block can accept a byte this cycle.
- `ram_read_addr`  out  11: to `display_ram` `read_addr`.
- `ram_r_en`  out  1: to `display_ram` `r_en`.
- `ram_dout`  in  6: from `display_ram` `dout`. Valid the cycle after `ram_r_en`.
- `ram_write_addr`  out  11: to `display_ram` `write_addr`.
- `ram_w_en`  out  1: to `display_ram` `w_en`.
- `ram_din`  out  6: to `display_ram` `din`.
- `cursor_addr`  out  11: current cursor position, row*COLS+col.
- `busy`  out  1: high in any state other than IDLE.

## Operation

- Handshake: `char_ready` = (state == IDLE). A byte transfers on a rising edge with `char_valid` && `char_ready`. `char_data` may change freely when not transferring.
- Cursor registers:
  - `col` (0..COLS-1) and `row` (0..ROWS-1).
  - `row_base` = row*COLS, kept incrementally; no multiplier.
  - `cursor_addr` = `row_base` + `col`.
- Code mapping for printable bytes:
  - 0x20–0x5F → `char_data[5:0]`.
  - 0x60–0x7F → `(char_data-0x20)[5:0]`, i.e. folded to upper case.
- Byte actions:
  - Printable: write code at `cursor_addr`, then advance. At `col`=COLS-1, set `col`=0 and do a line feed.
  - 0x0D CR: `col`=0.
  - 0x0A LF: `row`+1 with `col` unchanged. If `row`=ROWS-1, `row` stays and the block enters SCROLL.
  - 0x08 BS: if `col`>0, `col`-1; no erase. At `col`=0, no change.
  - 0x0C FF: enter CLEAR; the cursor goes to 0,0 once CLEAR completes.
  - Any other byte (<0x20 other than the above, or ≥0x80): consumed, no effect.
- States:
  - IDLE: accepts bytes.
  - SCROLL: copies rows 1..ROWS-1 to rows 0..ROWS-2, then enters BLANKLINE.
  - BLANKLINE: writes BLANK to the COLS cells of row ROWS-1, then returns to IDLE.
  - CLEAR: writes BLANK to all COLS*ROWS cells, sets the cursor to 0,0, then returns to IDLE.
- SCROLL pipeline:
  - Cycle k: `ram_read_addr` = k+COLS with `ram_r_en`=1, for k = 0 .. COLS*(ROWS-1)-1.
  - Cycle k+1: `ram_write_addr` = k, `ram_din` = `ram_dout`, `ram_w_en`=1.
  - Reads and writes overlap. A write never targets an address not yet read, because the write address is below the read address.
- Counters: the scan counter is 11-bit, with terminal count compared against the parameter product. Addresses never exceed COLS*ROWS-1.
- Reset behaviour:
  - Assertion: all outputs 0, cursor 0,0, state forced to CLEAR. The screen is therefore blanked after every reset.
  - Reset asserted mid-SCROLL or mid-CLEAR aborts immediately. No `ram_w_en` is generated while `rst_n`=0.

## Timing

- All RAM-side outputs and `cursor_addr` are registered. Outputs are driven in the cycle after the accepting edge; the RAM commits on the following edge.
- Printable throughput: one byte per cycle in IDLE when no wrap-to-scroll occurs.
- SCROLL plus BLANKLINE: `char_ready` is low for COLS*(ROWS-1)+1+COLS cycles. This is 1001 cycles at 40x25.
- CLEAR: `char_ready` low for COLS*ROWS cycles. This is 1000 at 40x25.
- Printable at the last cell (col COLS-1, row ROWS-1):
  - The character write is issued first.
  - SCROLL starts the next cycle.
  - The cursor ends at row ROWS-1, col 0.
- `ram_r_en` is high only in SCROLL.
- `busy` is the exact complement of `char_ready`.

## Test plan

- Reset release → `ram_w_en` high for 1000 consecutive cycles with addresses 0..999 and data 0x20, then `char_ready`=1 and `cursor_addr`=0.
- Send "Ab" at home → writes (0,0x01) then (1,0x02) on consecutive cycles; `cursor_addr`=2.
- Send 40 × 'X' from home → last write at addr 39; `cursor_addr`=40 (row 1, col 0); no scroll.
- Preload row 1 with distinct codes, place cursor at row 24, send LF:
  - row 0 receives the old row 1 contents;
  - addrs 960..999 receive 0x20;
  - `char_ready` is low for 1001 cycles;
  - `cursor_addr`=960+col.
- Send CR, BS at col 0, and 0x07 → cursor col 0 and unchanged; no `ram_w_en`; each byte accepted in 1 cycle.
- Assert `rst_n` low 10 cycles into SCROLL → outputs 0 immediately; after release a full 1000-cycle CLEAR follows.

Source files
------------

// File: rtl/display_writer.sv
// display_writer: ASCII stream to display_ram writer with cursor, hardware scroll and screen clear.
module display_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 25,
  parameter logic [5:0] BLANK = 6'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [10:0] ram_read_addr,
  output logic        ram_r_en,
  input  logic [5:0]  ram_dout,
  output logic [10:0] ram_write_addr,
  output logic        ram_w_en,
  output logic [5:0]  ram_din,
  output logic [10:0] cursor_addr,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SCROLL, BLANKLINE, CLEAR} state_t;
  localparam logic [10:0] CELLS = 11'(COLS * ROWS);
  localparam logic [10:0] SPAN = 11'(COLS * (ROWS - 1));
  localparam logic [10:0] W = 11'(COLS);
  localparam logic [10:0] LAST_COL = 11'(COLS - 1);
  localparam logic [10:0] LAST_ROW = 11'(ROWS - 1);
  state_t state, state_d;
  logic [10:0] cnt, cnt_d, col, col_d, row, row_d, row_base, row_base_d;
  logic [10:0] raddr_d, waddr_d;
  logic r_en_d, w_en_d, copy, copy_d, take, printable, lf;
  logic [5:0] din_r, din_d, code;
  assign char_ready = state == IDLE;
  assign busy = !char_ready;
  assign take = char_valid && char_ready;
  assign printable = char_data[7:5] == 3'b001 || char_data[7:6] == 2'b01;
  assign code = (char_data[6] && char_data[5]) ? char_data[5:0] - 6'h20 : char_data[5:0];
  assign lf = char_data == 8'h0A || (printable && col == LAST_COL);
  // Scroll copies pass read data straight through in the cycle it arrives from the RAM.
  assign ram_din = copy ? ram_dout : din_r;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    col_d = col;
    row_d = row;
    row_base_d = row_base;
    raddr_d = ram_read_addr;
    waddr_d = ram_write_addr;
    din_d = din_r;
    r_en_d = 1'b0;
    w_en_d = 1'b0;
    copy_d = 1'b0;
    unique case (state)
      IDLE: if (take) begin
        if (printable) begin
          w_en_d = 1'b1;
          waddr_d = cursor_addr;
          din_d = code;
          col_d = (col == LAST_COL) ? '0 : col + 11'd1;
        end else if (char_data == 8'h0D) col_d = '0;
        else if (char_data == 8'h08 && col != '0) col_d = col - 11'd1;
        else if (char_data == 8'h0C) begin
          state_d = CLEAR;
          cnt_d = '0;
        end
        if (lf && row == LAST_ROW) begin
          state_d = SCROLL;
          cnt_d = '0;
        end else if (lf) begin
          row_d = row + 11'd1;
          row_base_d = row_base + W;
        end
      end
      // Read of cell k+COLS issued at count k; its copy to cell k lands one count later.
      SCROLL: begin
        r_en_d = cnt != SPAN;
        raddr_d = r_en_d ? cnt + W : ram_read_addr;
        w_en_d = cnt != '0;
        copy_d = w_en_d;
        waddr_d = w_en_d ? cnt - 11'd1 : ram_write_addr;
        cnt_d = (cnt == SPAN) ? '0 : cnt + 11'd1;
        state_d = (cnt == SPAN) ? BLANKLINE : SCROLL;
      end
      BLANKLINE: begin
        w_en_d = 1'b1;
        waddr_d = SPAN + cnt;
        din_d = BLANK;
        cnt_d = (cnt == LAST_COL) ? '0 : cnt + 11'd1;
        state_d = (cnt == LAST_COL) ? IDLE : BLANKLINE;
      end
      CLEAR: begin
        w_en_d = 1'b1;
        waddr_d = cnt;
        din_d = BLANK;
        cnt_d = cnt + 11'd1;
        if (cnt == CELLS - 11'd1) begin
          state_d = IDLE;
          cnt_d = '0;
          col_d = '0;
          row_d = '0;
          row_base_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
      col <= '0;
      row <= '0;
      row_base <= '0;
      cursor_addr <= '0;
      ram_read_addr <= '0;
      ram_write_addr <= '0;
      din_r <= '0;
      ram_r_en <= 1'b0;
      ram_w_en <= 1'b0;
      copy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      col <= col_d;
      row <= row_d;
      row_base <= row_base_d;
      cursor_addr <= row_base_d + col_d;
      ram_read_addr <= raddr_d;
      ram_write_addr <= waddr_d;
      din_r <= din_d;
      ram_r_en <= r_en_d;
      ram_w_en <= w_en_d;
      copy <= copy_d;
    end
  end
endmodule

// File: tb/tb_display_writer.sv
// tb_display_writer: directed checks of display_writer against a behavioural display_ram.
module tb_display_writer;
  logic clk = 1'b0, rst_n = 1'b0, char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic char_ready, ram_r_en, ram_w_en, busy;
  logic [10:0] ram_read_addr, ram_write_addr, cursor_addr;
  logic [5:0] ram_dout, ram_din;
  logic [5:0] mem [0:2047];
  int tests = 0, fails = 0;
  display_writer dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .ram_read_addr(ram_read_addr), .ram_r_en(ram_r_en),
    .ram_dout(ram_dout), .ram_write_addr(ram_write_addr), .ram_w_en(ram_w_en),
    .ram_din(ram_din), .cursor_addr(cursor_addr), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_write_addr] <= ram_din;
    if (ram_r_en) ram_dout <= mem[ram_read_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!char_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!char_ready) chk("send_wait", char_ready, 1);
    char_valid = 1'b1;
    char_data = b;
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask
  task automatic wait_idle(output int n, output int rd);
    n = 0;
    rd = 0;
    while (!char_ready && n < 3000) begin
      n++;
      if (ram_r_en) rd++;
      @(posedge clk); #1;
    end
  endtask
  task automatic check_clear(input string tag);
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!(ram_w_en === 1'b1 && ram_write_addr === 11'(i) && ram_din === 6'h20)) bad++;
    end
    chk({tag, "_writes"}, bad, 0);
    chk({tag, "_ready"}, char_ready, 1);
    @(posedge clk); #1;
    chk({tag, "_wen_off"}, ram_w_en, 0);
    chk({tag, "_cursor"}, cursor_addr, 0);
  endtask
  initial begin
    int bad, n, rd;
    #12;
    chk("rst_wen", ram_w_en, 0);
    chk("rst_ren", ram_r_en, 0);
    chk("rst_cursor", cursor_addr, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_din", ram_din, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear("clr0");
    send(8'h41);
    chk("A_wen", ram_w_en, 1);
    chk("A_addr", ram_write_addr, 0);
    chk("A_din", ram_din, 6'h01);
    send(8'h62);
    chk("b_addr", ram_write_addr, 1);
    chk("b_din", ram_din, 6'h02);
    chk("Ab_cursor", cursor_addr, 2);
    send(8'h0D);
    chk("cr_cursor", cursor_addr, 0);
    chk("cr_wen", ram_w_en, 0);
    chk("cr_ready", char_ready, 1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      send(8'h58);
      if (!(ram_w_en === 1'b1 && ram_write_addr === 11'(i) && ram_din === 6'h18)) bad++;
    end
    chk("x40_writes", bad, 0);
    chk("x40_cursor", cursor_addr, 40);
    chk("x40_ready", char_ready, 1);
    send(8'h51);
    chk("Q_cursor", cursor_addr, 41);
    send(8'h08);
    chk("bs_cursor", cursor_addr, 40);
    chk("bs_wen", ram_w_en, 0);
    send(8'h08);
    chk("bs0_cursor", cursor_addr, 40);
    send(8'h07);
    chk("bel_cursor", cursor_addr, 40);
    chk("bel_wen", ram_w_en, 0);
    chk("bel_ready", char_ready, 1);
    send(8'h0D);
    chk("cr0_cursor", cursor_addr, 40);
    for (int i = 0; i < 40; i++) send(8'(8'h20 + i));
    chk("row1_cursor", cursor_addr, 80);
    for (int i = 0; i < 22; i++) send(8'h0A);
    chk("lf_cursor", cursor_addr, 960);
    for (int i = 0; i < 3; i++) send(8'h7A);
    chk("z_din", ram_din, 6'h1A);
    chk("z_cursor", cursor_addr, 963);
    send(8'h0A);
    wait_idle(n, rd);
    chk("scroll_busy", n, 1001);
    chk("scroll_reads", rd, 960);
    chk("scroll_cursor", cursor_addr, 963);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 40; i++) if (mem[i] !== 6'((8'h20 + i) & 8'h3F)) bad++;
    chk("scroll_row0", bad, 0);
    bad = 0;
    for (int i = 920; i < 923; i++) if (mem[i] !== 6'h1A) bad++;
    chk("scroll_row23", bad, 0);
    bad = 0;
    for (int i = 960; i < 1000; i++) if (mem[i] !== 6'h20) bad++;
    chk("scroll_blank", bad, 0);
    send(8'h0D);
    for (int i = 0; i < 39; i++) send(8'h20);
    send(8'h41);
    chk("last_addr", ram_write_addr, 999);
    chk("last_din", ram_din, 6'h01);
    chk("last_ready", char_ready, 0);
    wait_idle(n, rd);
    chk("last_busy", n, 1001);
    chk("last_cursor", cursor_addr, 960);
    @(posedge clk); #1;
    chk("last_moved", mem[959], 6'h01);
    send(8'h0A);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_wen", ram_w_en, 0);
    chk("abort_ren", ram_r_en, 0);
    chk("abort_cursor", cursor_addr, 0);
    chk("abort_raddr", ram_read_addr, 0);
    chk("abort_ready", char_ready, 0);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ram_w_en !== 1'b0) bad++;
    end
    chk("abort_hold", bad, 0);
    rst_n = 1'b1;
    check_clear("clr1");
    send(8'h41);
    chk("pre_ff_cursor", cursor_addr, 1);
    send(8'h0C);
    chk("ff_ready", char_ready, 0);
    check_clear("ff");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
